// File: rtl/risc_stack_pkg.sv
// Shared constants, level-width helper and push/pop op decode for the call stack.
package risc_stack_pkg;

  localparam int unsigned DefDataW = 12;
  localparam int unsigned DefDepth = 8;

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Encoded as {push, pop} so the request pins map straight onto the op.
  typedef enum logic [1:0] {
    OpNop     = 2'b00,
    OpPop     = 2'b01,
    OpPush    = 2'b10,
    OpPushPop = 2'b11
  } stack_op_e;

endpackage

// File: rtl/risc_stack_mem.sv
// Stack entry storage: single synchronous write port, single asynchronous read port.
module risc_stack_mem #(
  parameter int unsigned MEM_W = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [MEM_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [MEM_W-1:0]  rdata
);

  logic [MEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads only occur for non-power-of-two depths at level 0; never consumed.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/risc_stack_gen2.sv
// Parametrised PC/PSW LIFO with status flags, sticky errors and a registered pop port.
// Optional per-entry even parity is enabled by defining RISC_STACK_PARITY_EN.
module risc_stack_gen2
  import risc_stack_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pushenbl,
  input  logic                      popenbl,
  input  logic [DATA_W-1:0]         pushdatain,
  input  logic                      clr_err,
  output logic [DATA_W-1:0]         popdataout,
  output logic                      pop_valid,
  output logic                      stack_full,
  output logic                      stack_empty,
  output logic                      half_full,
  output logic                      almost_full,
  output logic [level_w(DEPTH)-1:0] level,
`ifdef RISC_STACK_PARITY_EN
  output logic                      parity_err,
  output logic                      parity_err_sticky,
`endif
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned LvlW  = level_w(DEPTH);
  localparam int unsigned AddrW = $clog2(DEPTH);
`ifdef RISC_STACK_PARITY_EN
  localparam int unsigned MemW  = DATA_W + 1;
`else
  localparam int unsigned MemW  = DATA_W;
`endif

  logic [LvlW-1:0]   level_q, level_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [LvlW-1:0]   top_idx;
  logic              is_full, is_empty;
  logic              mem_we;
  logic [AddrW-1:0]  mem_waddr;
  logic [MemW-1:0]   mem_wdata, mem_rdata;
  logic              mem_pop;
  stack_op_e         op;

  assign op       = stack_op_e'({pushenbl, popenbl});
  assign top_idx  = level_q - LvlW'(1);
  assign is_full  = (level_q == LvlW'(DEPTH));
  assign is_empty = (level_q == '0);

`ifdef RISC_STACK_PARITY_EN
  assign mem_wdata = {^pushdatain, pushdatain};
`else
  assign mem_wdata = pushdatain;
`endif

  always_comb begin
    level_d     = level_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    mem_we      = 1'b0;
    mem_waddr   = top_idx[AddrW-1:0];
    mem_pop     = 1'b0;
    unique case (op)
      OpPush: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = level_q[AddrW-1:0];
          level_d   = level_q + LvlW'(1);
        end
      end
      OpPop: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          mem_pop     = 1'b1;
          pop_data_d  = mem_rdata[DATA_W-1:0];
          pop_valid_d = 1'b1;
          level_d     = top_idx;
        end
      end
      OpPushPop: begin
        pop_valid_d = 1'b1;
        if (is_empty) begin
          pop_data_d = pushdatain;
        end else begin
          // Replace the top entry: read old value and write new one in the same cycle.
          mem_pop    = 1'b1;
          pop_data_d = mem_rdata[DATA_W-1:0];
          mem_we     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef RISC_STACK_PARITY_EN
  logic par_err_q, par_err_d;
  logic par_sticky_q, par_sticky_d;

  always_comb begin
    par_err_d    = mem_pop & (^mem_rdata);
    par_sticky_d = (par_sticky_q & ~clr_err) | par_err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_q    <= 1'b0;
      par_sticky_q <= 1'b0;
    end else begin
      par_err_q    <= par_err_d;
      par_sticky_q <= par_sticky_d;
    end
  end

  assign parity_err        = par_err_q;
  assign parity_err_sticky = par_sticky_q;
`else
  logic unused_mem_pop;
  assign unused_mem_pop = mem_pop;
`endif

  risc_stack_mem #(
    .MEM_W (MemW),
    .DEPTH (DEPTH),
    .ADDR_W(AddrW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(top_idx[AddrW-1:0]),
    .rdata(mem_rdata)
  );

  assign popdataout  = pop_data_q;
  assign pop_valid   = pop_valid_q;
  assign level       = level_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign half_full   = (level_q >= LvlW'(DEPTH / 2));
  assign almost_full = (level_q >= LvlW'(AFULL_LVL));
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_risc_stack_gen2.sv
// Scoreboard bench for risc_stack_gen2: queue-based LIFO model, decoupled monitor.
module tb_risc_stack_gen2;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFULL = DEPTH - 1;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, pushenbl, popenbl, clr_err;
  logic [DW-1:0] pushdatain;
  logic [DW-1:0] popdataout;
  logic          pop_valid, stack_full, stack_empty, half_full, almost_full;
  logic [LW-1:0] level;
  logic          overflow, underflow;
`ifdef RISC_STACK_PARITY_EN
  logic          parity_err, parity_err_sticky;
`endif

  risc_stack_gen2 #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk        (clk),
    .reset      (reset),
    .pushenbl   (pushenbl),
    .popenbl    (popenbl),
    .pushdatain (pushdatain),
    .clr_err    (clr_err),
    .popdataout (popdataout),
    .pop_valid  (pop_valid),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .half_full  (half_full),
    .almost_full(almost_full),
    .level      (level),
`ifdef RISC_STACK_PARITY_EN
    .parity_err       (parity_err),
    .parity_err_sticky(parity_err_sticky),
`endif
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0] lvl;
    logic          full, empty, half, afull, ovf, udf, pv;
    logic [DW-1:0] data;
  } status_t;

  status_t       exp_status_q[$];
  logic [DW-1:0] exp_pop_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            stim_done = 1'b0;

  // Reference model state: the stack is a plain queue, top at the back.
  logic [DW-1:0] m_stk[$];
  logic [DW-1:0] m_last = '0;
  logic          m_ovf = 1'b0, m_udf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the DUT must show after the next edge.
  task automatic step(input bit push, input bit pop, input logic [DW-1:0] d,
                      input bit clr, input bit rst);
    status_t s;
    bit      pv = 1'b0;
    bit      ovf_set = 1'b0, udf_set = 1'b0;
    @(negedge clk);
    reset = rst; pushenbl = push; popenbl = pop; pushdatain = d; clr_err = clr;
    if (rst) begin
      m_stk.delete(); m_last = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (push && pop) begin
        pv = 1'b1;
        if (m_stk.size() == 0) m_last = d;
        else begin m_last = m_stk.pop_back(); m_stk.push_back(d); end
      end else if (push) begin
        if (m_stk.size() == DEPTH) ovf_set = 1'b1;
        else m_stk.push_back(d);
      end else if (pop) begin
        if (m_stk.size() == 0) udf_set = 1'b1;
        else begin m_last = m_stk.pop_back(); pv = 1'b1; end
      end
      m_ovf = ovf_set | (m_ovf & ~clr);
      m_udf = udf_set | (m_udf & ~clr);
      if (pv) exp_pop_q.push_back(m_last);
    end
    s.lvl   = LW'(m_stk.size());
    s.full  = (m_stk.size() == DEPTH);
    s.empty = (m_stk.size() == 0);
    s.half  = (m_stk.size() >= DEPTH / 2);
    s.afull = (m_stk.size() >= AFULL);
    s.ovf   = m_ovf;
    s.udf   = m_udf;
    s.pv    = pv;
    s.data  = m_last;
    exp_status_q.push_back(s);
  endtask

  // Monitor: compares status every cycle and pop data on every pop_valid pulse.
  initial begin
    status_t e;
    logic [DW-1:0] pe;
    forever begin
      @(posedge clk);
      #1;
      if (exp_status_q.size() > 0) begin
        e = exp_status_q.pop_front();
        chk("level", int'(level), int'(e.lvl));
        chk("stack_full", int'(stack_full), int'(e.full));
        chk("stack_empty", int'(stack_empty), int'(e.empty));
        chk("half_full", int'(half_full), int'(e.half));
        chk("almost_full", int'(almost_full), int'(e.afull));
        chk("overflow", int'(overflow), int'(e.ovf));
        chk("underflow", int'(underflow), int'(e.udf));
        chk("pop_valid", int'(pop_valid), int'(e.pv));
        chk("popdataout_hold", int'(popdataout), int'(e.data));
        if (pop_valid === 1'b1) begin
          if (exp_pop_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_unexpected: got 0x%0h expected no pop", popdataout);
          end else begin
            pe = exp_pop_q.pop_front();
            chk("pop_data", int'(popdataout), int'(pe));
          end
        end
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1; pushenbl = 1'b0; popenbl = 1'b0; pushdatain = '0; clr_err = 1'b0;
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    // Fill to full, then overflow, then drain.
    for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), 0, 0);
    step(1, 0, 12'h0AA, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    // Underflow, and clr_err losing to a same-cycle underflow.
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    // Replace-top at level 3, then pop the replaced value.
    for (int i = 1; i <= 3; i++) step(1, 0, DW'(i), 0, 0);
    step(1, 1, 12'h7FF, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    // Empty bypass.
    step(1, 1, 12'h123, 0, 0);
    // Reset during a push at level 5.
    for (int i = 1; i <= 5; i++) step(1, 0, DW'(i + 16), 0, 0);
    step(1, 0, 12'h0FF, 0, 1);
    step(0, 0, '0, 0, 0);
    // Full push+pop replaces top without error.
    for (int i = 0; i < 8; i++) step(1, 0, DW'($urandom), 0, 0);
    step(1, 1, 12'hABC, 0, 0);
    step(0, 1, '0, 0, 0);
    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), DW'($urandom),
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 999) < 5));
    end
    step(0, 0, '0, 0, 0);
    stim_done = 1'b1;
    budget = 0;
    while (exp_status_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_status_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d status entries left, expected 0", exp_status_q.size());
    end
    checks++;
    if (exp_pop_q.size() != 0) begin
      errors++;
      $display("FAIL pop_queue_drain: %0d pops left, expected 0", exp_pop_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
